// File: rtl/fifo_rd_stream_if.sv
// Read-side FIFO port plus downstream valid/ready stream, bundled for fifo_rd_stream.
// master: the streaming block; slave: the FIFO/downstream environment.
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
);
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;

    modport master (
        input  rempty,
        input  rdata,
        output rinc,
        output m_valid,
        input  m_ready,
        output m_data
    );

    modport slave (
        output rempty,
        output rdata,
        input  rinc,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO read port into a 2-entry valid/ready output buffer (FALLTHROUGH "TRUE"/"FALSE").
// Defining FIFO_RD_WORDCNT_EN adds the 16-bit wrapping wordcnt output of delivered words.
module fifo_rd_stream #(
    parameter int    DSIZE       = 8,
    parameter string FALLTHROUGH = "TRUE"
) (
    input  logic               rclk,
    input  logic               rrst,
    fifo_rd_stream_if.master   bus,
    output logic [1:0]         buf_level
`ifdef FIFO_RD_WORDCNT_EN
    ,
    output logic [15:0]        wordcnt
`endif
);

    localparam bit FWFT = (FALLTHROUGH == "TRUE");

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;
    logic             pending_q, pending_d;
    logic [1:0]       level_s;
    logic [1:0]       occ_s;
    logic             m_valid_s;
    logic             pop_s;
    logic             push_s;
    logic             rinc_s;

    assign level_s = state_q;

    // Output decode: everything downstream sees comes straight from flops.
    always_comb begin
        m_valid_s = 1'b0;
        case (state_q)
            ST_EMPTY: m_valid_s = 1'b0;
            ST_ONE:   m_valid_s = 1'b1;
            ST_FULL:  m_valid_s = 1'b1;
            default:  m_valid_s = 1'b0;
        endcase
    end

    // Read request: words held or in flight, net of this cycle's pop, must stay below 2.
    always_comb begin
        pop_s  = m_valid_s && bus.m_ready;
        occ_s  = level_s + {1'b0, pending_q};
        rinc_s = !bus.rempty && !rrst && ((occ_s - {1'b0, pop_s}) < 2'd2);
        if (FWFT) begin
            push_s    = rinc_s;
            pending_d = 1'b0;
        end else begin
            push_s    = pending_q;
            pending_d = rinc_s;
        end
    end

    // Next-state: occupancy moves only when push and pop differ.
    always_comb begin
        state_d = state_q;
        case ({push_s, pop_s})
            2'b10:   state_d = (state_q == ST_EMPTY) ? ST_ONE : ST_FULL;
            2'b01:   state_d = (state_q == ST_FULL) ? ST_ONE : ST_EMPTY;
            default: state_d = state_q;
        endcase
    end

    // Buffer data: pop shifts tail into head, then the push lands in the first free slot.
    always_comb begin
        if (pop_s) begin
            head_d = tail_q;
        end else begin
            head_d = head_q;
        end
        tail_d = tail_q;
        if (push_s) begin
            if ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && pop_s)) begin
                head_d = bus.rdata;
            end else begin
                tail_d = bus.rdata;
            end
        end else begin
            tail_d = tail_q;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q   <= ST_EMPTY;
            pending_q <= 1'b0;
            head_q    <= {DSIZE{1'b0}};
            tail_q    <= {DSIZE{1'b0}};
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

    assign bus.rinc    = rinc_s;
    assign bus.m_valid = m_valid_s;
    assign bus.m_data  = head_q;
    assign buf_level   = level_s;

`ifdef FIFO_RD_WORDCNT_EN
    logic [15:0] wordcnt_q, wordcnt_d;

    // Delivered-word counter, wraps naturally at 16 bits.
    always_comb begin
        if (pop_s) begin
            wordcnt_d = wordcnt_q + 16'd1;
        end else begin
            wordcnt_d = wordcnt_q;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            wordcnt_q <= 16'd0;
        end else begin
            wordcnt_q <= wordcnt_d;
        end
    end

    assign wordcnt = wordcnt_q;
`endif

endmodule
